// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared size encodings, FSM states and mem_ctl field positions
package mem_access_unit_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_DRAIN} state_e;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam int CTL_SIGN  = 0;
   localparam int CTL_SZ    = 1;
   localparam int CTL_ST    = 3;
   localparam int CTL_LD    = 4;
   localparam int WDEST_LSB = 0;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
   endfunction
endpackage

// File: rtl/mem_lsalign.sv
// mem_lsalign: store strobe/data replication and load byte/half extraction with extension
module mem_lsalign
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [1:0]  lo,
   input  logic [31:0] sd,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] ld_data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b       = rdata[{lo, 3'b000} +: 8];
      h       = rdata[{lo[1], 4'b0000} +: 16];
      wstrb   = size == SZ_BYTE ? 4'b0001 << lo : size == SZ_HALF ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata   = size == SZ_BYTE ? {4{sd[7:0]}} : size == SZ_HALF ? {2{sd[15:0]}} : sd;
      ld_data = size == SZ_BYTE ? {{24{sign & b[7]}}, b} : size == SZ_HALF ? {{16{sign & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage driving a split address/data memory handshake
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int PASS_W    = 80,
   parameter bit ALIGN_CHK = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              MEM_valid,
   input  logic [4:0]        mem_ctl,
   input  logic [31:0]       exe_result,
   input  logic [31:0]       store_data,
   input  logic [PASS_W-1:0] pass_in,
   input  logic              cancel,
   input  logic              MEM_allow_in,
   output logic              MEM_over,
   output logic [4:0]        MEM_wdest,
   output logic              dm_req,
   output logic              dm_wr,
   output logic [1:0]        dm_size,
   output logic [31:0]       dm_addr,
   output logic [3:0]        dm_wstrb,
   output logic [31:0]       dm_wdata,
   input  logic              dm_addr_ok,
   input  logic              dm_data_ok,
   input  logic [31:0]       dm_rdata,
   output logic [31:0]       mem_result,
   output logic              ade,
   output logic              ade_st,
   output logic [31:0]       badvaddr,
   output logic [PASS_W-1:0] pass_out
);
   state_e      state_q, state_d;
   logic [31:0] cap_q, cap_d, ld_src, ld_data, wdata;
   logic [3:0]  wstrb;
   logic [1:0]  size, lo_mask;
   logic        ld, st, sign, is_mem;

   always_comb begin
      ld       = mem_ctl[CTL_LD];
      st       = mem_ctl[CTL_ST];
      size     = mem_ctl[CTL_SZ +: 2];
      sign     = mem_ctl[CTL_SIGN];
      is_mem   = ld | st;
      lo_mask  = size == SZ_HALF ? 2'b01 : size == SZ_WORD ? 2'b11 : 2'b00;
      dm_addr  = ALIGN_CHK ? exe_result : {exe_result[31:2], exe_result[1:0] & ~lo_mask};
      ade      = ALIGN_CHK && MEM_valid && is_mem && misaligned(size, exe_result[1:0]);
      ade_st   = ade & st;
      badvaddr = ade ? exe_result : 32'd0;
      ld_src   = state_q == ST_DONE ? cap_q : dm_rdata;
   end

   mem_lsalign u_lsalign (
      .size    (size),
      .sign    (sign),
      .lo      (dm_addr[1:0]),
      .sd      (store_data),
      .rdata   (ld_src),
      .wstrb   (wstrb),
      .wdata   (wdata),
      .ld_data (ld_data)
   );

   always_comb begin
      dm_req     = resetn && state_q == ST_IDLE && MEM_valid && is_mem && !ade && !cancel;
      dm_wr      = st;
      dm_size    = size;
      dm_wstrb   = resetn && st ? wstrb : 4'b0000;
      dm_wdata   = wdata;
      MEM_over   = resetn && MEM_valid && !cancel && state_q != ST_DRAIN &&
                   (!is_mem || ade || (state_q == ST_WAIT && dm_data_ok) || state_q == ST_DONE);
      mem_result = ld ? ld_data : exe_result;
      MEM_wdest  = MEM_valid ? pass_in[WDEST_LSB +: 5] : 5'd0;
      pass_out   = pass_in;
      state_d    = state_q;
      cap_d      = cap_q;
      case (state_q)
         ST_IDLE:  state_d = dm_req && dm_addr_ok ? ST_WAIT : ST_IDLE;
         ST_WAIT: begin
            state_d = dm_data_ok ? (cancel || MEM_allow_in ? ST_IDLE : ST_DONE) : (cancel ? ST_DRAIN : ST_WAIT);
            cap_d   = dm_data_ok && !cancel && !MEM_allow_in ? dm_rdata : cap_q;
         end
         ST_DONE:  state_d = cancel || MEM_allow_in ? ST_IDLE : ST_DONE;
         default:  state_d = dm_data_ok ? ST_IDLE : ST_DRAIN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cap_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of both alignment modes against a transaction model
module tb_mem_access_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, MEM_valid, cancel, MEM_allow_in, dm_addr_ok, dm_data_ok, rn_drv;
   logic [4:0]  mem_ctl;
   logic [31:0] exe_result, store_data, dm_rdata;
   logic [79:0] pass_in;

   logic        MEM_over, dm_req, dm_wr, ade, ade_st;
   logic [4:0]  MEM_wdest;
   logic [1:0]  dm_size;
   logic [31:0] dm_addr, dm_wdata, mem_result, badvaddr;
   logic [3:0]  dm_wstrb;
   logic [79:0] pass_out;

   logic        b_MEM_over, b_dm_req, b_dm_wr, b_ade, b_ade_st;
   logic [4:0]  b_MEM_wdest;
   logic [1:0]  b_dm_size;
   logic [31:0] b_dm_addr, b_dm_wdata, b_mem_result, b_badvaddr;
   logic [3:0]  b_dm_wstrb;
   logic [79:0] b_pass_out;

   int checks = 0;
   int failures = 0;

   mem_access_unit #(.PASS_W(80), .ALIGN_CHK(1'b1)) dut_a (
      .clk(clk), .resetn(resetn), .MEM_valid(MEM_valid), .mem_ctl(mem_ctl), .exe_result(exe_result),
      .store_data(store_data), .pass_in(pass_in), .cancel(cancel), .MEM_allow_in(MEM_allow_in),
      .MEM_over(MEM_over), .MEM_wdest(MEM_wdest), .dm_req(dm_req), .dm_wr(dm_wr), .dm_size(dm_size),
      .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata), .dm_addr_ok(dm_addr_ok),
      .dm_data_ok(dm_data_ok), .dm_rdata(dm_rdata), .mem_result(mem_result), .ade(ade),
      .ade_st(ade_st), .badvaddr(badvaddr), .pass_out(pass_out)
   );

   mem_access_unit #(.PASS_W(80), .ALIGN_CHK(1'b0)) dut_b (
      .clk(clk), .resetn(resetn), .MEM_valid(MEM_valid), .mem_ctl(mem_ctl), .exe_result(exe_result),
      .store_data(store_data), .pass_in(pass_in), .cancel(cancel), .MEM_allow_in(MEM_allow_in),
      .MEM_over(b_MEM_over), .MEM_wdest(b_MEM_wdest), .dm_req(b_dm_req), .dm_wr(b_dm_wr), .dm_size(b_dm_size),
      .dm_addr(b_dm_addr), .dm_wstrb(b_dm_wstrb), .dm_wdata(b_dm_wdata), .dm_addr_ok(dm_addr_ok),
      .dm_data_ok(dm_data_ok), .dm_rdata(dm_rdata), .mem_result(b_mem_result), .ade(b_ade),
      .ade_st(b_ade_st), .badvaddr(b_badvaddr), .pass_out(b_pass_out)
   );

   function automatic logic [3:0] m_wstrb(input logic st, input logic [1:0] sz, input logic [31:0] a);
      if (!st) return 4'h0;
      if (sz == 2'd0) return 4'(1 << (a % 4));
      if (sz == 2'd1) return (a % 4) >= 2 ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
      if (sz == 2'd0) return {24'd0, sd[7:0]} * 32'h01010101;
      if (sz == 2'd1) return {16'd0, sd[15:0]} * 32'h00010001;
      return sd;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (rd >> ((a % 4) * 8)) & 32'hFF;
         if (sg && v > 127) v = v - 32'd256;
      end else if (sz == 2'd1) begin
         v = (rd >> ((a % 4) >= 2 ? 16 : 0)) & 32'hFFFF;
         if (sg && v > 32767) v = v - 32'd65536;
      end else v = rd;
      return v;
   endfunction

   task automatic set_side();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      pass_in = t[79:0];
      store_data = $urandom();
   endtask

   task automatic drv(input logic v, input logic [4:0] c, input logic [31:0] a, input logic canc,
                      input logic aok, input logic dok, input logic [31:0] rd, input logic alw);
      @(negedge clk);
      resetn = rn_drv; MEM_valid = v; mem_ctl = c; exe_result = a; cancel = canc;
      dm_addr_ok = aok; dm_data_ok = dok; dm_rdata = rd; MEM_allow_in = alw;
      #1;
   endtask

   task automatic mem_op(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input int ao, input int dd, input int al, input logic [31:0] rd);
      logic [4:0] c;
      int td;
      c = {ld, st, sz, sg};
      td = ao + 1 + dd;
      for (int k = 0; k <= td + al; k++) begin
         drv(1'b1, c, a, 1'b0, k == ao, k == td, k == td ? rd : $urandom(),
             k < td ? ($urandom() & 1) != 0 : k == td + al);
         checks++;
         if ({dm_req, MEM_over, b_dm_req, b_MEM_over} !== {k <= ao, k >= td, k <= ao, k >= td}) begin
            failures++;
            $display("FAIL mem_op_handshake a=%h k=%0d: got req/over/b_req/b_over=%b want %b", a, k,
                     {dm_req, MEM_over, b_dm_req, b_MEM_over}, {k <= ao, k >= td, k <= ao, k >= td});
         end
         if (k <= ao) begin
            checks++;
            if ({dm_wr, dm_size, dm_addr, dm_wstrb, dm_wdata} !== {st, sz, a, m_wstrb(st, sz, a), m_wdata(sz, store_data)}) begin
               failures++;
               $display("FAIL mem_op_request a=%h: got wr=%b size=%0d addr=%h strb=%b wdata=%h want wr=%b size=%0d addr=%h strb=%b wdata=%h",
                        a, dm_wr, dm_size, dm_addr, dm_wstrb, dm_wdata, st, sz, a, m_wstrb(st, sz, a), m_wdata(sz, store_data));
            end
         end
         if (k >= td) begin
            checks++;
            if (mem_result !== (ld ? m_load(sz, sg, a, rd) : a)) begin
               failures++;
               $display("FAIL mem_op_result a=%h k=%0d: got %h want %h", a, k, mem_result, ld ? m_load(sz, sg, a, rd) : a);
            end
         end
      end
      checks++;
      if ({ade, ade_st, badvaddr, MEM_wdest, pass_out} !== {1'b0, 1'b0, 32'd0, pass_in[4:0], pass_in}) begin
         failures++;
         $display("FAIL mem_op_side a=%h: got ade=%b bad=%h wdest=%h pass=%h want ade=0 bad=0 wdest=%h pass=%h",
                  a, ade, badvaddr, MEM_wdest, pass_out, pass_in[4:0], pass_in);
      end
   endtask

   task automatic ade_op(input logic st, input logic [1:0] sz, input logic [31:0] a);
      logic [31:0] masked;
      masked = a & (sz == 2'd2 ? 32'hFFFFFFFC : 32'hFFFFFFFE);
      drv(1'b1, {!st, st, sz, 1'b0}, a, 1'b0, 1'b0, 1'b0, $urandom(), 1'b1);
      checks++;
      if ({dm_req, ade, ade_st, MEM_over, badvaddr} !== {1'b0, 1'b1, st, 1'b1, a}) begin
         failures++;
         $display("FAIL ade_chk a=%h: got req/ade/ade_st/over=%b bad=%h want %b bad=%h", a,
                  {dm_req, ade, ade_st, MEM_over}, badvaddr, {1'b0, 1'b1, st, 1'b1}, a);
      end
      checks++;
      if ({b_dm_req, b_ade, b_ade_st, b_MEM_over, b_badvaddr, b_dm_addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, masked}) begin
         failures++;
         $display("FAIL ade_nochk a=%h: got req/ade/ade_st/over=%b bad=%h addr=%h want 1000 bad=0 addr=%h", a,
                  {b_dm_req, b_ade, b_ade_st, b_MEM_over}, b_badvaddr, b_dm_addr, masked);
      end
   endtask

   task automatic nonmem_op(input logic [31:0] a);
      set_side();
      drv(1'b1, {2'b00, 2'($urandom_range(2)), 1'($urandom_range(1))}, a, 1'b0, 1'b0, 1'b0, $urandom(), 1'b1);
      checks++;
      if ({dm_req, MEM_over, ade, dm_wstrb, mem_result, MEM_wdest, pass_out} !== {1'b0, 1'b1, 1'b0, 4'h0, a, pass_in[4:0], pass_in}) begin
         failures++;
         $display("FAIL nonmem a=%h: got req/over/ade=%b strb=%b res=%h wdest=%h want 010 strb=0 res=%h wdest=%h",
                  a, {dm_req, MEM_over, ade}, dm_wstrb, mem_result, MEM_wdest, a, pass_in[4:0]);
      end
   endtask

   task automatic bubble();
      drv(1'b0, 5'b10100, $urandom(), 1'b0, 1'b0, 1'b0, $urandom(), 1'b1);
      checks++;
      if ({dm_req, MEM_over, MEM_wdest, b_dm_req, b_MEM_over} !== 9'd0) begin
         failures++;
         $display("FAIL bubble: got req/over=%b wdest=%h b_req/b_over=%b want all 0",
                  {dm_req, MEM_over}, MEM_wdest, {b_dm_req, b_MEM_over});
      end
   endtask

   task automatic test_reset();
      rn_drv = 1'b0;
      set_side();
      drv(1'b1, 5'b01100, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({dm_req, dm_wstrb, MEM_over, b_dm_req, b_dm_wstrb, b_MEM_over} !== 12'd0) begin
         failures++;
         $display("FAIL reset_store: got req/strb/over=%b b=%b want 0",
                  {dm_req, dm_wstrb, MEM_over}, {b_dm_req, b_dm_wstrb, b_MEM_over});
      end
      drv(1'b1, 5'b00100, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({MEM_over, b_MEM_over} !== 2'b00) begin
         failures++;
         $display("FAIL reset_nonmem: got over=%b b_over=%b want 0 0", MEM_over, b_MEM_over);
      end
      rn_drv = 1'b1;
      drv(1'b1, 5'b10100, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({dm_req, MEM_over} !== 2'b10) begin
         failures++;
         $display("FAIL reset_release: got req/over=%b want 10", {dm_req, MEM_over});
      end
      rn_drv = 1'b0;
      drv(1'b1, 5'b10100, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({dm_req, MEM_over, b_dm_req, b_MEM_over} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_in_wait: got req/over/b_req/b_over=%b want 0000", {dm_req, MEM_over, b_dm_req, b_MEM_over});
      end
      rn_drv = 1'b1;
      mem_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 0, 0, 0, 32'h13572468);
   endtask

   task automatic test_directed();
      set_side();
      mem_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 0, 0, 0, 32'h8899AABB);
      mem_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 0, 0, 0, 32'h80FFFFFF);
      mem_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 1, 2, 0, 32'h80FF1234);
      store_data = 32'h0000ABCD;
      mem_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 0, 0, 0, 32'h0);
      ade_op(1'b0, 2'd2, 32'h101);
      ade_op(1'b1, 2'd1, 32'h203);
      mem_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 0, 0, 3, 32'hCAFEF00D);
      nonmem_op(32'hDEADBEEF);
      bubble();
   endtask

   task automatic test_cancel();
      drv(1'b1, 5'b10100, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      drv(1'b1, 5'b10100, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({dm_req, MEM_over} !== 2'b00) begin
         failures++;
         $display("FAIL cancel_wait: got req/over=%b want 00", {dm_req, MEM_over});
      end
      drv(1'b1, 5'b00100, 32'h304, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({dm_req, MEM_over, b_MEM_over} !== 3'b000) begin
         failures++;
         $display("FAIL drain_nonmem: got req/over/b_over=%b want 000", {dm_req, MEM_over, b_MEM_over});
      end
      for (int k = 0; k < 2; k++) begin
         drv(1'b1, 5'b10100, 32'h308, 1'b0, 1'b0, k == 1, 32'h5A5A5A5A, 1'b1);
         checks++;
         if ({dm_req, MEM_over, b_dm_req, b_MEM_over} !== 4'b0000) begin
            failures++;
            $display("FAIL drain_hold k=%0d: got req/over/b_req/b_over=%b want 0000", k, {dm_req, MEM_over, b_dm_req, b_MEM_over});
         end
      end
      mem_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h308, 0, 1, 0, 32'h01020304);
      drv(1'b1, 5'b10100, 32'h310, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      drv(1'b1, 5'b10100, 32'h310, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
      checks++;
      if ({dm_req, MEM_over} !== 2'b00) begin
         failures++;
         $display("FAIL cancel_with_data: got req/over=%b want 00", {dm_req, MEM_over});
      end
      mem_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h311, 0, 0, 0, 32'h0);
      drv(1'b1, 5'b10100, 32'h320, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      drv(1'b1, 5'b10100, 32'h320, 1'b0, 1'b0, 1'b1, 32'h11112222, 1'b0);
      drv(1'b1, 5'b10100, 32'h320, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({dm_req, MEM_over} !== 2'b00) begin
         failures++;
         $display("FAIL cancel_done: got req/over=%b want 00", {dm_req, MEM_over});
      end
      mem_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h322, 0, 0, 0, 32'h8001FFFF);
      drv(1'b1, 5'b10100, 32'h330, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({dm_req, MEM_over, b_dm_req} !== 3'b000) begin
         failures++;
         $display("FAIL cancel_idle: got req/over/b_req=%b want 000", {dm_req, MEM_over, b_dm_req});
      end
      mem_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h330, 2, 0, 1, 32'h76543210);
   endtask

   task automatic test_random_back_to_back();
      logic [31:0] a;
      logic [1:0]  sz;
      logic        st;
      int          kind;
      for (int n = 0; n < 120; n++) begin
         kind = $urandom_range(9);
         sz = 2'($urandom_range(2));
         st = ($urandom() & 1) != 0;
         a = $urandom();
         if (kind < 2) nonmem_op(a);
         else if (kind == 2) bubble();
         else if (kind == 3 && sz != 2'd0) begin
            a = sz == 2'd2 ? (a & 32'hFFFFFFFC) | 32'($urandom_range(1, 3)) : a | 32'd1;
            ade_op(st, sz, a);
         end else begin
            a = sz == 2'd2 ? a & 32'hFFFFFFFC : sz == 2'd1 ? a & 32'hFFFFFFFE : a;
            set_side();
            mem_op(!st, st, sz, ($urandom() & 1) != 0, a, $urandom_range(3), $urandom_range(3),
                   $urandom_range(3), $urandom());
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; rn_drv = 1'b0; MEM_valid = 1'b0; mem_ctl = 5'd0; exe_result = 32'd0;
      store_data = 32'd0; pass_in = 80'd0; cancel = 1'b0; MEM_allow_in = 1'b0;
      dm_addr_ok = 1'b0; dm_data_ok = 1'b0; dm_rdata = 32'd0;
      test_reset();
      test_directed();
      test_cancel();
      test_random_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
